// File: rtl/ysyx_24100013_immenc.sv
// RV32 instruction encoder: packs type/fields/immediate into an instruction word.
// One registered output stage with a valid/ready handshake and a handoff counter.
module ysyx_24100013_immenc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       itype,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt
);

    localparam logic [2:0] T_I = 3'b001;
    localparam logic [2:0] T_S = 3'b010;
    localparam logic [2:0] T_B = 3'b011;
    localparam logic [2:0] T_U = 3'b100;
    localparam logic [2:0] T_J = 3'b101;

    logic             valid_q;
    logic [31:0]      inst_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      inst_d;
    logic             err_d;
    logic             accept;
    logic             handoff;

    // funct7 is reserved for a future R-type path
    logic unused_funct7;
    assign unused_funct7 = ^funct7;

    // A field fits when every bit above its sign bit matches the sign bit
    logic fit12;
    logic fit13;
    logic fit21;
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        inst_d = 32'h0;
        err_d  = 1'b1;
        unique case (itype)
            T_I: begin
                inst_d = {imm[11:0], rs1, funct3, rd, opcode};
                err_d  = ~fit12;
            end
            T_S: begin
                inst_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err_d  = ~fit12;
            end
            T_B: begin
                inst_d = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], opcode};
                err_d  = ~fit13 | imm[0];
            end
            T_U: begin
                inst_d = {imm[31:12], rd, opcode};
                err_d  = |imm[11:0];
            end
            T_J: begin
                inst_d = {imm[20], imm[10:1], imm[11], imm[19:12],
                          rd, opcode};
                err_d  = ~fit21 | imm[0];
            end
            default: begin
                inst_d = 32'h0;
                err_d  = 1'b1;
            end
        endcase
    end

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign handoff  = valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                inst_q  <= inst_d;
                err_q   <= err_d;
            end else if (handoff) begin
                valid_q <= 1'b0;
            end
            if (handoff) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = valid_q;
    assign inst      = inst_q;
    assign err       = err_q;
    assign enc_cnt   = cnt_q;

endmodule

// File: doc/ysyx_24100013_immenc.md
Name: ysyx_24100013_immenc

Overview:
- Instruction encoder: inverse of the core's immediate/type decode path. Packs the instruction type, opcode, register fields, funct fields and a 32-bit signed immediate into a 32-bit RV32 instruction word.
- Checks that the immediate fits the selected format.
- Single registered output stage with valid/ready handshake. Feeds test-program generation and self-check loops that compare against the decoder.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  encode request valid
- in_ready  out  1  encoder can accept a request
- itype  in  3  001 I, 010 S, 011 B, 100 U, 101 J; other codes invalid
- opcode  in  7  placed at inst[6:0]
- funct3  in  3  placed at inst[14:12] (I/S/B only)
- funct7  in  7  unused; reserved for R-type, ignored for now
- rd  in  5  inst[11:7] (I/U/J)
- rs1  in  5  inst[19:15] (I/S/B)
- rs2  in  5  inst[24:20] (S/B)
- imm  in  32  signed immediate; byte offset for B/J; full upper value for U
- out_valid  out  1  inst valid
- out_ready  in  1  downstream accepts
- inst  out  32  encoded instruction
- err  out  1  immediate out of range, or invalid itype, for the current inst
- enc_cnt  out  CNT_W  number of instructions handed off downstream

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, inst=0, err=0, enc_cnt=0. rst overrides any in-flight handshake; a pending output is discarded.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at posedge. inst/err register on that edge and out_valid=1 the next cycle (latency 1). Full throughput with out_ready held 1.
- Output handshake: out_valid && out_ready. If no new accept on the same edge, out_valid goes to 0. Simultaneous accept and handoff: new word loads and out_valid stays 1.
- While out_valid && !out_ready: inst and err stay stable; no accept.
- enc_cnt increments by 1 on each output handshake and wraps modulo 2^CNT_W.
- Field packing (x = imm):
  - I: {x[11:0], rs1, funct3, rd, opcode}.
  - S: {x[11:5], rs2, rs1, funct3, x[4:0], opcode}.
  - B: {x[12], x[10:5], rs2, rs1, funct3, x[4:1], x[11], opcode}.
  - U: {x[31:12], rd, opcode}.
  - J: {x[20], x[10:1], x[11], x[19:12], rd, opcode}.
  - Invalid itype: inst=32'h0, err=1.
- Range check (err=1 when violated; inst is still emitted with the truncated fields):
  - I/S: x[31:11] all equal (12-bit signed).
  - B: x[31:12] all equal, and x[0]=0.
  - U: x[11:0]=0.
  - J: x[31:20] all equal, and x[0]=0.
- Unused input fields for a format are ignored and do not affect inst or err.

Test Plan:
- I-type, opcode=0x13, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF -> inst=0xFFF00093, err=0, one cycle after accept.
- S-type, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. B-type, opcode=0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3, err=0.
- J-type, opcode=0x6F, rd=1, imm=0x10 -> 0x010000EF. Same request with imm=0x11 -> err=1. U-type with imm=0x12345001 -> err=1, inst[31:12]=0x12345.
- I-type imm=0x800 -> err=1, inst[31:20]=0x800. itype=3'b111 -> inst=0, err=1.
- Backpressure: out_ready=0 after the first accept -> in_ready=0, inst stable for 5 cycles, enc_cnt unchanged. Then in_valid=1 held across the out_ready=1 cycle -> new word out next cycle, no bubble, enc_cnt+1.
- rst pulsed while out_valid=1 && out_ready=0 -> next cycle out_valid=0, enc_cnt=0. Streaming 2^CNT_W+3 words -> enc_cnt=3.
